// File: rtl/mem_read_responder.sv
// Cache-refill memory responder: one word read at a time, answered Latency cycles after acceptance.
// Define MEM_RESP_OOR_EN to add mem_err for addresses with bits above the array index set.
module mem_read_responder #(
  parameter int AddrBusWidth = 32,
  parameter int MemBusWidth  = 64,
  parameter int Depth        = 1024,
  parameter int Latency      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AddrBusWidth-1:0]  mem_addr,
  input  logic                     mem_avail,
  output logic [MemBusWidth-1:0]   mem_data,
  output logic                     mem_busy,
  output logic                     mem_done,
`ifdef MEM_RESP_OOR_EN
  output logic                     mem_err,
`endif
  input  logic                     init_we,
  input  logic [$clog2(Depth)-1:0] init_addr,
  input  logic [MemBusWidth-1:0]   init_data
);

  localparam int ByteBits = $clog2(MemBusWidth / 8);
  localparam int IdxBits  = $clog2(Depth);
  localparam int CntW     = (Latency > 1) ? $clog2(Latency) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [CntW-1:0]        cnt, cnt_nxt;
  logic                   capture, load;
  logic [IdxBits-1:0]     addr_idx, idx_q, rd_idx;
  logic [MemBusWidth-1:0] mem [Depth];
  logic                   rd_oor;
  logic                   unused_addr;

  assign addr_idx    = mem_addr[ByteBits+IdxBits-1:ByteBits];
  assign rd_idx      = (state == IDLE) ? addr_idx : idx_q;
  assign unused_addr = ^mem_addr;

`ifdef MEM_RESP_OOR_EN
  logic addr_oor, oor_q;
  assign addr_oor = (mem_addr >> (ByteBits + IdxBits)) != '0;
  assign rd_oor   = (state == IDLE) ? addr_oor : oor_q;
`else
  assign rd_oor = 1'b0;
`endif

  // Backdoor port; nonblocking update means a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_data;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_avail) begin
          capture = 1'b1;
          cnt_nxt = CntW'(Latency - 1);
          if (Latency == 1) begin
            state_nxt = DONE;
            load      = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt_nxt == '0) begin
          state_nxt = DONE;
          load      = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they never follow mem_avail combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      mem_busy <= 1'b0;
      mem_done <= 1'b0;
      mem_data <= '0;
`ifdef MEM_RESP_OOR_EN
      oor_q    <= 1'b0;
      mem_err  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mem_busy <= (state_nxt != IDLE);
      mem_done <= (state_nxt == DONE);
      mem_data <= (load && !rd_oor) ? mem[rd_idx] : '0;
      if (capture) idx_q <= addr_idx;
`ifdef MEM_RESP_OOR_EN
      if (capture) oor_q <= addr_oor;
      mem_err <= load && rd_oor;
`endif
    end
  end

endmodule

// File: tb/tb_mem_read_responder.sv
// Self-checking bench for mem_read_responder: scoreboard of expected done words plus timing checks.
module tb_mem_read_responder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_avail = 1'b0;
  logic [63:0] mem_data;
  logic        mem_busy, mem_done;
  logic        init_we = 1'b0;
  logic [9:0]  init_addr = '0;
  logic [63:0] init_data = '0;
`ifdef MEM_RESP_OOR_EN
  logic        mem_err;
`endif

  mem_read_responder #(.AddrBusWidth(32), .MemBusWidth(64), .Depth(1024), .Latency(LAT)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_avail(mem_avail),
    .mem_data(mem_data), .mem_busy(mem_busy), .mem_done(mem_done),
`ifdef MEM_RESP_OOR_EN
    .mem_err(mem_err),
`endif
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  bit          mon_en = 1'b0;
  logic [63:0] exp_q[$];
  bit          err_q[$];
  int          done_times[$];
  logic [63:0] model[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse pops one expected word; outside done, data must be zero.
  always @(negedge clk) begin
    logic [63:0] e;
    bit          ee;
    if (mon_en) begin
      if (mem_done === 1'b1) begin
        done_cnt++;
        done_times.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done with data=%h, required no done", mem_data);
        end else begin
          e  = exp_q.pop_front();
          ee = err_q.pop_front();
          if (mem_data !== e) begin
            errors++;
            $display("FAIL done_data: got %h, required %h", mem_data, e);
          end
`ifdef MEM_RESP_OOR_EN
          checks++;
          if (mem_err !== ee) begin
            errors++;
            $display("FAIL done_err: got %b, required %b", mem_err, ee);
          end
`endif
        end
      end else begin
        checks++;
        if (mem_data !== 64'h0) begin
          errors++;
          $display("FAIL idle_data: got %h, required 0", mem_data);
        end
`ifdef MEM_RESP_OOR_EN
        checks++;
        if (mem_err !== 1'b0) begin
          errors++;
          $display("FAIL idle_err: got %b, required 0", mem_err);
        end
`endif
      end
    end
  end

  // Drives a one-cycle strobe; returns #1 after the edge that samples it.
  task automatic send(input logic [31:0] addr);
    @(posedge clk); #1;
    mem_addr  = addr;
    mem_avail = 1'b1;
    @(posedge clk); #1;
    mem_avail = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b, required 0", k, mem_busy); end
      checks++;
      if (mem_done !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b, required 0", k, mem_done); end
      checks++;
      if (mem_data !== 64'h0) begin errors++; $display("FAIL reset_data[%0d]: got %h, required 0", k, mem_data); end
    end
    mon_en = 1'b1;
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++)
      model[i] = (i == 3) ? 64'hDEAD_BEEF_0123_4567 : {16'hA5A5, 16'(i), 32'hC0DE_0000 + 32'(i)};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      init_we   = 1'b1;
      init_addr = 10'(i);
      init_data = model[i];
    end
    @(posedge clk); #1 init_we = 1'b0;
  endtask

  task automatic test_single();
    int acc, d0;
    d0 = done_cnt;
    exp_q.push_back(64'hDEAD_BEEF_0123_4567); err_q.push_back(1'b0);
    send(32'h18);
    acc = cyc;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      checks++;
      if (mem_busy !== 1'b1) begin errors++; $display("FAIL single_busy[%0d]: got %b, required 1", k, mem_busy); end
      checks++;
      if (mem_done !== (k == LAT)) begin errors++; $display("FAIL single_done[%0d]: got %b, required %b", k, mem_done, (k == LAT)); end
    end
    @(negedge clk);
    checks++;
    if (mem_busy !== 1'b0 || mem_done !== 1'b0) begin
      errors++; $display("FAIL single_after: got busy=%b done=%b, required 0 0", mem_busy, mem_done);
    end
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL single_count: got %0d, required %0d", done_cnt - d0, 1); end
    checks++;
    if (done_times.size() == 0 || done_times[$] - acc !== LAT - 1) begin
      errors++; $display("FAIL single_latency: got done at edge offset %0d, required %0d",
                         (done_times.size() == 0) ? -1 : done_times[$] - acc, LAT - 1);
    end
  endtask

  task automatic test_ignore_strobes();
    int d0;
    d0 = done_cnt;
    exp_q.push_back(model[1]); err_q.push_back(1'b0);
    send(32'h8);
    @(posedge clk); #1 mem_addr = 32'h10; mem_avail = 1'b1;   // sampled in WAIT
    @(posedge clk); #1 mem_avail = 1'b0;
    @(posedge clk); #1 mem_avail = 1'b1;                       // sampled in DONE
    @(posedge clk); #1 mem_avail = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ignore_count: got %0d dones, required 1", done_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ignore_pending: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int d0, n0;
    d0 = done_cnt;
    n0 = done_times.size();
    exp_q.push_back(model[1]); err_q.push_back(1'b0);
    exp_q.push_back(model[2]); err_q.push_back(1'b0);
    @(posedge clk); #1 mem_addr = 32'h8; mem_avail = 1'b1;
    @(posedge clk); #1 mem_addr = 32'h10;
    repeat (5) @(posedge clk);
    #1 mem_avail = 1'b0;
    for (int k = 0; k < 20 && done_cnt < d0 + 2; k++) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 2) begin errors++; $display("FAIL b2b_count: got %0d dones, required 2", done_cnt - d0); end
    checks++;
    if (done_times.size() < n0 + 2 || done_times[n0+1] - done_times[n0] !== 5) begin
      errors++; $display("FAIL b2b_gap: got %0d cycles, required 5",
                         (done_times.size() < n0 + 2) ? -1 : done_times[n0+1] - done_times[n0]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int d0;
    d0 = done_cnt;
    send(32'h18);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_busy !== 1'b0 || mem_done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b done=%b, required 0 0", mem_busy, mem_done);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done: got %0d dones, required 0", done_cnt - d0); end
    exp_q.push_back(64'hDEAD_BEEF_0123_4567); err_q.push_back(1'b0);
    send(32'h18);
    for (int k = 0; k < 20 && done_cnt < d0 + 1; k++) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL abort_recover: got %0d dones, required 1", done_cnt - d0); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_before_write();
    int d0;
    d0 = done_cnt;
    exp_q.push_back(model[5]); err_q.push_back(1'b0);
    send(32'h28);
    @(posedge clk); #1;
    @(posedge clk); #1 init_we = 1'b1; init_addr = 10'd5; init_data = 64'h0BAD_F00D_5555_AAAA;
    @(posedge clk); #1 init_we = 1'b0;
    model[5] = 64'h0BAD_F00D_5555_AAAA;
    repeat (3) @(negedge clk);
    exp_q.push_back(model[5]); err_q.push_back(1'b0);
    send(32'h2F);
    for (int k = 0; k < 20 && done_cnt < d0 + 2; k++) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 2) begin errors++; $display("FAIL rbw_count: got %0d dones, required 2", done_cnt - d0); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_high_address();
    int d0;
    d0 = done_cnt;
`ifdef MEM_RESP_OOR_EN
    exp_q.push_back(64'h0); err_q.push_back(1'b1);
`else
    exp_q.push_back(model[0]); err_q.push_back(1'b0);
`endif
    send(32'h0000_2000);
    for (int k = 0; k < 20 && done_cnt < d0 + 1; k++) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL high_addr_count: got %0d dones, required 1", done_cnt - d0); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    preload();
    test_single();
    test_ignore_strobes();
    test_back_to_back();
    test_reset_abort();
    test_read_before_write();
    test_high_address();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: got %0d outstanding, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
